// File: rtl/hazard3_mem_bridge.sv
// hazard3_mem_bridge
//
// Connects the Hazard3 instruction-fetch port (suffix _i) and load/store port
// (suffix _d) to a single-ported synchronous RAM with 1-cycle read latency.
// The load/store port has fixed priority over fetch. Every data phase
// completes in the cycle after its address phase. Write data arrives in the
// data phase, so a write uses the RAM port in the cycle after acceptance.
// During that cycle neither address phase is accepted.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus_*_i               fetch port: aph req/ready, dph ready/err, addr,
//                         size, rdata (panic and priv are ignored)
//   bus_*_d               load/store port: aph req/excl/ready, dph ready/err/
//                         exokay, addr, size, write, wdata, rdata (priv ignored)
//   mem_en, mem_we        RAM enable / write enable
//   mem_addr              RAM word address
//   mem_wmask, mem_wdata  RAM byte write enables and write data
//   mem_rdata             RAM read data, valid the cycle after a read
//
// Optional feature: define HAZARD3_MEM_BRIDGE_EXCL_EN to add a single-entry
// reservation monitor for exclusive accesses. When the macro is undefined,
// bus_dph_exokay_d is tied to 0 and exclusive writes are always performed.

module hazard3_mem_bridge #(
    parameter int unsigned W_ADDR         = 32,
    parameter int unsigned W_DATA         = 32,
    parameter int unsigned MEM_WORDS_LOG2 = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      bus_aph_req_i,
    input  logic                      bus_aph_panic_i,
    output logic                      bus_aph_ready_i,
    output logic                      bus_dph_ready_i,
    output logic                      bus_dph_err_i,
    input  logic [W_ADDR-1:0]         bus_haddr_i,
    input  logic [2:0]                bus_hsize_i,
    input  logic                      bus_priv_i,
    output logic [W_DATA-1:0]         bus_rdata_i,

    input  logic                      bus_aph_req_d,
    input  logic                      bus_aph_excl_d,
    output logic                      bus_aph_ready_d,
    output logic                      bus_dph_ready_d,
    output logic                      bus_dph_err_d,
    output logic                      bus_dph_exokay_d,
    input  logic [W_ADDR-1:0]         bus_haddr_d,
    input  logic [2:0]                bus_hsize_d,
    input  logic                      bus_priv_d,
    input  logic                      bus_hwrite_d,
    input  logic [W_DATA-1:0]         bus_wdata_d,
    output logic [W_DATA-1:0]         bus_rdata_d,

    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_WORDS_LOG2-1:0] mem_addr,
    output logic [3:0]                mem_wmask,
    output logic [W_DATA-1:0]         mem_wdata,
    input  logic [W_DATA-1:0]         mem_rdata
);

    // Byte-address width covered by the RAM
    localparam int unsigned BYTE_AW = MEM_WORDS_LOG2 + 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        RD_D,
        WR_D,
        ERR_I,
        ERR_D
    } slot_t;

    slot_t                     slot;
    slot_t                     slot_nxt;
    logic [MEM_WORDS_LOG2-1:0] slot_addr;
    logic [3:0]                slot_mask;

    logic legal_i;
    logic legal_d;
    logic write_ok;

    logic unused_ok;
    assign unused_ok = ^{bus_aph_panic_i, bus_priv_i, bus_priv_d};

    // The access must be in range, naturally aligned, and at most a word wide
    function automatic logic access_legal(input logic [W_ADDR-1:0] addr,
                                          input logic [2:0]        size);
        logic ok;
        ok = ((addr >> BYTE_AW) == '0);
        case (size)
            3'd0:    ok = ok;
            3'd1:    ok = ok & ~addr[0];
            3'd2:    ok = ok & (addr[1:0] == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lsb,
                                             input logic [2:0] size);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << lsb;
            3'd1:    m = 4'b0011 << lsb;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    assign legal_i = access_legal(bus_haddr_i, bus_hsize_i);
    assign legal_d = access_legal(bus_haddr_d, bus_hsize_d);

    // The RAM port is busy with write data in a WR_D data phase
    assign bus_aph_ready_d = bus_aph_req_d & (slot != WR_D);
    assign bus_aph_ready_i = bus_aph_req_i & ~bus_aph_req_d & (slot != WR_D);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= IDLE;
            slot_addr <= '0;
            slot_mask <= '0;
        end else begin
            slot <= slot_nxt;
            if (bus_aph_ready_d) begin
                slot_addr <= bus_haddr_d[MEM_WORDS_LOG2+1:2];
                slot_mask <= lane_mask(bus_haddr_d[1:0], bus_hsize_d);
            end
        end
    end

`ifdef HAZARD3_MEM_BRIDGE_EXCL_EN
    logic                      slot_excl;
    logic                      resv_valid;
    logic [MEM_WORDS_LOG2-1:0] resv_addr;

    // The reservation is updated when the data phase completes: an exclusive
    // read sets it, and any write (successful or not) clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_excl  <= 1'b0;
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else begin
            if (bus_aph_ready_d) begin
                slot_excl <= bus_aph_excl_d;
            end
            if (slot == WR_D) begin
                resv_valid <= 1'b0;
            end else if ((slot == RD_D) && slot_excl) begin
                resv_valid <= 1'b1;
                resv_addr  <= slot_addr;
            end
        end
    end

    assign write_ok = ~slot_excl | (resv_valid & (resv_addr == slot_addr));
`else
    logic unused_excl;
    assign unused_excl = bus_aph_excl_d;
    assign write_ok    = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        slot_nxt = IDLE;
        if (bus_aph_ready_d) begin
            if (!legal_d) begin
                slot_nxt = ERR_D;
            end else if (bus_hwrite_d) begin
                slot_nxt = WR_D;
            end else begin
                slot_nxt = RD_D;
            end
        end else if (bus_aph_ready_i) begin
            slot_nxt = legal_i ? RD_I : ERR_I;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_en           = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = slot_addr;
        mem_wmask        = '0;
        mem_wdata        = bus_wdata_d;

        bus_dph_ready_i  = 1'b0;
        bus_dph_err_i    = 1'b0;
        bus_rdata_i      = '0;
        bus_dph_ready_d  = 1'b0;
        bus_dph_err_d    = 1'b0;
        bus_dph_exokay_d = 1'b0;
        bus_rdata_d      = '0;

        // RAM port: a pending write owns the port; otherwise a legal read
        // address phase drives it, with the data port first.
        if (slot == WR_D) begin
            mem_en    = write_ok;
            mem_we    = write_ok;
            mem_wmask = write_ok ? slot_mask : 4'b0000;
        end else if (bus_aph_ready_d) begin
            if (legal_d && !bus_hwrite_d) begin
                mem_en   = 1'b1;
                mem_addr = bus_haddr_d[MEM_WORDS_LOG2+1:2];
            end
        end else if (bus_aph_ready_i && legal_i) begin
            mem_en   = 1'b1;
            mem_addr = bus_haddr_i[MEM_WORDS_LOG2+1:2];
        end

        case (slot)
            RD_I: begin
                bus_dph_ready_i = 1'b1;
                bus_rdata_i     = mem_rdata;
            end
            ERR_I: begin
                bus_dph_ready_i = 1'b1;
                bus_dph_err_i   = 1'b1;
            end
            RD_D: begin
                bus_dph_ready_d = 1'b1;
                bus_rdata_d     = mem_rdata;
            end
            WR_D: begin
                bus_dph_ready_d = 1'b1;
            end
            ERR_D: begin
                bus_dph_ready_d = 1'b1;
                bus_dph_err_d   = 1'b1;
            end
            default: begin
            end
        endcase

`ifdef HAZARD3_MEM_BRIDGE_EXCL_EN
        bus_dph_exokay_d = slot_excl &
                           ((slot == RD_D) || ((slot == WR_D) && write_ok));
`endif
    end

endmodule

// File: tb/tb_hazard3_mem_bridge.sv
// Directed testbench for hazard3_mem_bridge. A behavioural RAM with 1-cycle
// read latency sits on the mem_* port. Inputs are driven on the falling edge,
// and outputs are checked 1 ns later, before the next rising edge.

module tb_hazard3_mem_bridge;

    localparam int unsigned W_ADDR         = 32;
    localparam int unsigned W_DATA         = 32;
    localparam int unsigned MEM_WORDS_LOG2 = 13;

`ifdef HAZARD3_MEM_BRIDGE_EXCL_EN
    localparam logic EXCL = 1'b1;
`else
    localparam logic EXCL = 1'b0;
`endif

    logic                      clk;
    logic                      rst_n;
    logic                      bus_aph_req_i;
    logic                      bus_aph_panic_i;
    logic                      bus_aph_ready_i;
    logic                      bus_dph_ready_i;
    logic                      bus_dph_err_i;
    logic [W_ADDR-1:0]         bus_haddr_i;
    logic [2:0]                bus_hsize_i;
    logic                      bus_priv_i;
    logic [W_DATA-1:0]         bus_rdata_i;
    logic                      bus_aph_req_d;
    logic                      bus_aph_excl_d;
    logic                      bus_aph_ready_d;
    logic                      bus_dph_ready_d;
    logic                      bus_dph_err_d;
    logic                      bus_dph_exokay_d;
    logic [W_ADDR-1:0]         bus_haddr_d;
    logic [2:0]                bus_hsize_d;
    logic                      bus_priv_d;
    logic                      bus_hwrite_d;
    logic [W_DATA-1:0]         bus_wdata_d;
    logic [W_DATA-1:0]         bus_rdata_d;
    logic                      mem_en;
    logic                      mem_we;
    logic [MEM_WORDS_LOG2-1:0] mem_addr;
    logic [3:0]                mem_wmask;
    logic [W_DATA-1:0]         mem_wdata;
    logic [W_DATA-1:0]         mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    hazard3_mem_bridge #(
        .W_ADDR         (W_ADDR),
        .W_DATA         (W_DATA),
        .MEM_WORDS_LOG2 (MEM_WORDS_LOG2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus_aph_req_i    (bus_aph_req_i),
        .bus_aph_panic_i  (bus_aph_panic_i),
        .bus_aph_ready_i  (bus_aph_ready_i),
        .bus_dph_ready_i  (bus_dph_ready_i),
        .bus_dph_err_i    (bus_dph_err_i),
        .bus_haddr_i      (bus_haddr_i),
        .bus_hsize_i      (bus_hsize_i),
        .bus_priv_i       (bus_priv_i),
        .bus_rdata_i      (bus_rdata_i),
        .bus_aph_req_d    (bus_aph_req_d),
        .bus_aph_excl_d   (bus_aph_excl_d),
        .bus_aph_ready_d  (bus_aph_ready_d),
        .bus_dph_ready_d  (bus_dph_ready_d),
        .bus_dph_err_d    (bus_dph_err_d),
        .bus_dph_exokay_d (bus_dph_exokay_d),
        .bus_haddr_d      (bus_haddr_d),
        .bus_hsize_d      (bus_hsize_d),
        .bus_priv_d       (bus_priv_d),
        .bus_hwrite_d     (bus_hwrite_d),
        .bus_wdata_d      (bus_wdata_d),
        .bus_rdata_d      (bus_rdata_d),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wmask        (mem_wmask),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM, preloaded on its first clock edge
    logic [31:0] ram [0:(1<<MEM_WORDS_LOG2)-1];
    logic        loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < (1 << MEM_WORDS_LOG2); i++) ram[i] <= 32'h0;
            ram[0]    <= 32'h11223344;
            ram[1]    <= 32'hCAFEF00D;
            ram[2]    <= 32'h0BADF00D;
            ram[4]    <= 32'hDEADBEEF;
            ram[5]    <= 32'h01020304;
            ram[8]    <= 32'h55667788;
            mem_rdata <= 32'h0;
            loaded    <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic idle_inputs();
        bus_aph_req_i   = 1'b0;
        bus_aph_panic_i = 1'b0;
        bus_haddr_i     = '0;
        bus_hsize_i     = 3'd2;
        bus_priv_i      = 1'b0;
        bus_aph_req_d   = 1'b0;
        bus_aph_excl_d  = 1'b0;
        bus_haddr_d     = '0;
        bus_hsize_d     = 3'd2;
        bus_priv_d      = 1'b0;
        bus_hwrite_d    = 1'b0;
        bus_wdata_d     = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if ({bus_dph_ready_i, bus_dph_ready_d} !== 2'b00) begin n_bad++; $display("FAIL reset_dph_ready: got %b want 00", {bus_dph_ready_i, bus_dph_ready_d}); end
        n_cmp++; if ({bus_dph_err_i, bus_dph_err_d, bus_dph_exokay_d} !== 3'b000) begin n_bad++; $display("FAIL reset_err_exokay: got %b want 000", {bus_dph_err_i, bus_dph_err_d, bus_dph_exokay_d}); end
        n_cmp++; if ({mem_en, mem_we} !== 2'b00) begin n_bad++; $display("FAIL reset_mem_en_we: got %b want 00", {mem_en, mem_we}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        bus_aph_req_i = 1'b1; bus_haddr_i = 32'h10; bus_hsize_i = 3'd2;
        #1;
        n_cmp++; if (bus_aph_ready_i !== 1'b1) begin n_bad++; $display("FAIL fetch_aph_ready: got %b want 1", bus_aph_ready_i); end
        n_cmp++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 13'd4}) begin n_bad++; $display("FAIL fetch_mem: got en=%b we=%b addr=%0h want en=1 we=0 addr=4", mem_en, mem_we, mem_addr); end
        @(negedge clk);
        bus_aph_req_i = 1'b0;
        #1;
        n_cmp++; if ({bus_dph_ready_i, bus_dph_err_i} !== 2'b10) begin n_bad++; $display("FAIL fetch_dph: got ready=%b err=%b want ready=1 err=0", bus_dph_ready_i, bus_dph_err_i); end
        n_cmp++; if (bus_rdata_i !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fetch_rdata: got %h want deadbeef", bus_rdata_i); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus_dph_ready_i !== 1'b0) begin n_bad++; $display("FAIL fetch_idle_ready: got %b want 0", bus_dph_ready_i); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus_aph_req_i = 1'b1; bus_haddr_i = 32'h10;
        @(negedge clk);
        bus_haddr_i = 32'h14;
        #1;
        n_cmp++; if ({bus_dph_ready_i, bus_aph_ready_i} !== 2'b11) begin n_bad++; $display("FAIL b2b_overlap: got dph=%b aph=%b want 1 1", bus_dph_ready_i, bus_aph_ready_i); end
        n_cmp++; if (bus_rdata_i !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_rdata0: got %h want deadbeef", bus_rdata_i); end
        n_cmp++; if (mem_addr !== 13'd5) begin n_bad++; $display("FAIL b2b_mem_addr: got %0h want 5", mem_addr); end
        @(negedge clk);
        bus_aph_req_i = 1'b0;
        #1;
        n_cmp++; if (bus_rdata_i !== 32'h01020304 || bus_dph_ready_i !== 1'b1) begin n_bad++; $display("FAIL b2b_rdata1: got %h ready=%b want 01020304 ready=1", bus_rdata_i, bus_dph_ready_i); end
    endtask

    task automatic test_arbitration();
        @(negedge clk);
        bus_aph_req_i = 1'b1; bus_haddr_i = 32'h10;
        bus_aph_req_d = 1'b1; bus_haddr_d = 32'h4; bus_hsize_d = 3'd2; bus_hwrite_d = 1'b0;
        #1;
        n_cmp++; if ({bus_aph_ready_d, bus_aph_ready_i} !== 2'b10) begin n_bad++; $display("FAIL arb_aph: got d=%b i=%b want d=1 i=0", bus_aph_ready_d, bus_aph_ready_i); end
        n_cmp++; if (mem_addr !== 13'd1) begin n_bad++; $display("FAIL arb_mem_addr: got %0h want 1", mem_addr); end
        @(negedge clk);
        bus_aph_req_d = 1'b0;
        #1;
        n_cmp++; if ({bus_dph_ready_d, bus_dph_ready_i, bus_aph_ready_i} !== 3'b101) begin n_bad++; $display("FAIL arb_second: got dph_d=%b dph_i=%b aph_i=%b want 1 0 1", bus_dph_ready_d, bus_dph_ready_i, bus_aph_ready_i); end
        n_cmp++; if (bus_rdata_d !== 32'hCAFEF00D) begin n_bad++; $display("FAIL arb_rdata_d: got %h want cafef00d", bus_rdata_d); end
        @(negedge clk);
        bus_aph_req_i = 1'b0;
        #1;
        n_cmp++; if ({bus_dph_ready_i, bus_dph_ready_d} !== 2'b10 || bus_rdata_i !== 32'hDEADBEEF) begin n_bad++; $display("FAIL arb_rdata_i: got %h ready_i=%b ready_d=%b want deadbeef 1 0", bus_rdata_i, bus_dph_ready_i, bus_dph_ready_d); end
    endtask

    task automatic test_byte_store();
        @(negedge clk);
        bus_aph_req_i = 1'b1; bus_haddr_i = 32'h10;
        bus_aph_req_d = 1'b1; bus_haddr_d = 32'h3; bus_hsize_d = 3'd0; bus_hwrite_d = 1'b1;
        #1;
        n_cmp++; if ({bus_aph_ready_d, mem_en, mem_we} !== 3'b100) begin n_bad++; $display("FAIL bstore_aph: got ready=%b en=%b we=%b want 1 0 0", bus_aph_ready_d, mem_en, mem_we); end
        @(negedge clk);
        bus_haddr_d = 32'h0; bus_hsize_d = 3'd2; bus_hwrite_d = 1'b0; bus_wdata_d = 32'hAB000000;
        #1;
        n_cmp++; if ({mem_en, mem_we, mem_wmask, mem_addr} !== {2'b11, 4'b1000, 13'd0}) begin n_bad++; $display("FAIL bstore_mem: got en=%b we=%b mask=%b addr=%0h want 1 1 1000 0", mem_en, mem_we, mem_wmask, mem_addr); end
        n_cmp++; if (mem_wdata !== 32'hAB000000) begin n_bad++; $display("FAIL bstore_wdata: got %h want ab000000", mem_wdata); end
        n_cmp++; if ({bus_dph_ready_d, bus_aph_ready_d, bus_aph_ready_i} !== 3'b100) begin n_bad++; $display("FAIL bstore_busy: got dph_d=%b aph_d=%b aph_i=%b want 1 0 0", bus_dph_ready_d, bus_aph_ready_d, bus_aph_ready_i); end
        @(negedge clk);
        bus_aph_req_i = 1'b0;
        #1;
        n_cmp++; if ({bus_aph_ready_d, mem_en, mem_we} !== 3'b110) begin n_bad++; $display("FAIL bstore_load_aph: got ready=%b en=%b we=%b want 1 1 0", bus_aph_ready_d, mem_en, mem_we); end
        @(negedge clk);
        bus_aph_req_d = 1'b0;
        #1;
        n_cmp++; if (bus_rdata_d !== 32'hAB223344) begin n_bad++; $display("FAIL bstore_readback: got %h want ab223344", bus_rdata_d); end
    endtask

    task automatic test_half_store();
        @(negedge clk);
        bus_aph_req_d = 1'b1; bus_haddr_d = 32'h6; bus_hsize_d = 3'd1; bus_hwrite_d = 1'b1;
        @(negedge clk);
        bus_aph_req_d = 1'b0; bus_wdata_d = 32'h12340000;
        #1;
        n_cmp++; if ({mem_we, mem_wmask, mem_addr} !== {1'b1, 4'b1100, 13'd1}) begin n_bad++; $display("FAIL hstore_mem: got we=%b mask=%b addr=%0h want 1 1100 1", mem_we, mem_wmask, mem_addr); end
        @(negedge clk);
        bus_aph_req_d = 1'b1; bus_haddr_d = 32'h4; bus_hsize_d = 3'd2; bus_hwrite_d = 1'b0;
        @(negedge clk);
        bus_aph_req_d = 1'b0;
        #1;
        n_cmp++; if (bus_rdata_d !== 32'h1234F00D) begin n_bad++; $display("FAIL hstore_readback: got %h want 1234f00d", bus_rdata_d); end
    endtask

    task automatic test_error();
        @(negedge clk);
        bus_aph_req_d = 1'b1; bus_haddr_d = 32'h2; bus_hsize_d = 3'd2; bus_hwrite_d = 1'b0;
        #1;
        n_cmp++; if ({bus_aph_ready_d, mem_en} !== 2'b10) begin n_bad++; $display("FAIL err_misalign_aph: got ready=%b en=%b want 1 0", bus_aph_ready_d, mem_en); end
        @(negedge clk);
        bus_aph_req_d = 1'b0;
        bus_aph_req_i = 1'b1; bus_haddr_i = 32'h8000; bus_hsize_i = 3'd2;
        #1;
        n_cmp++; if ({bus_dph_ready_d, bus_dph_err_d, bus_rdata_d} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL err_misalign_dph: got ready=%b err=%b rdata=%h want 1 1 0", bus_dph_ready_d, bus_dph_err_d, bus_rdata_d); end
        n_cmp++; if ({bus_aph_ready_i, mem_en} !== 2'b10) begin n_bad++; $display("FAIL err_range_aph: got ready=%b en=%b want 1 0", bus_aph_ready_i, mem_en); end
        @(negedge clk);
        bus_aph_req_i = 1'b0;
        bus_aph_req_d = 1'b1; bus_haddr_d = 32'h7FFF; bus_hsize_d = 3'd0;
        #1;
        n_cmp++; if ({bus_dph_ready_i, bus_dph_err_i, bus_rdata_i} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL err_range_dph: got ready=%b err=%b rdata=%h want 1 1 0", bus_dph_ready_i, bus_dph_err_i, bus_rdata_i); end
        n_cmp++; if ({mem_en, mem_addr} !== {1'b1, 13'h1FFF}) begin n_bad++; $display("FAIL err_last_byte_mem: got en=%b addr=%0h want 1 1fff", mem_en, mem_addr); end
        @(negedge clk);
        bus_aph_req_d = 1'b0;
        #1;
        n_cmp++; if ({bus_dph_ready_d, bus_dph_err_d} !== 2'b10) begin n_bad++; $display("FAIL err_last_byte_dph: got ready=%b err=%b want 1 0", bus_dph_ready_d, bus_dph_err_d); end
    endtask

    task automatic test_exclusive();
        @(negedge clk);
        bus_aph_req_d = 1'b1; bus_aph_excl_d = 1'b1; bus_haddr_d = 32'h20; bus_hsize_d = 3'd2; bus_hwrite_d = 1'b0;
        @(negedge clk);
        bus_hwrite_d = 1'b1;
        #1;
        n_cmp++; if ({bus_dph_ready_d, bus_dph_exokay_d} !== {1'b1, EXCL} || bus_rdata_d !== 32'h55667788) begin n_bad++; $display("FAIL excl_load: got ready=%b exokay=%b rdata=%h want 1 %b 55667788", bus_dph_ready_d, bus_dph_exokay_d, bus_rdata_d, EXCL); end
        @(negedge clk);
        bus_aph_req_d = 1'b0; bus_wdata_d = 32'h0A0A0A0A;
        #1;
        n_cmp++; if ({bus_dph_ready_d, mem_we, bus_dph_exokay_d} !== {2'b11, EXCL}) begin n_bad++; $display("FAIL excl_store1: got ready=%b we=%b exokay=%b want 1 1 %b", bus_dph_ready_d, mem_we, bus_dph_exokay_d, EXCL); end
        @(negedge clk);
        bus_aph_req_d = 1'b1;
        @(negedge clk);
        bus_aph_req_d = 1'b0; bus_wdata_d = 32'h0B0B0B0B;
        #1;
        n_cmp++; if ({bus_dph_ready_d, mem_we, bus_dph_exokay_d} !== {1'b1, ~EXCL, 1'b0}) begin n_bad++; $display("FAIL excl_store2: got ready=%b we=%b exokay=%b want 1 %b 0", bus_dph_ready_d, mem_we, bus_dph_exokay_d, ~EXCL); end
        @(negedge clk);
        bus_aph_req_d = 1'b1; bus_aph_excl_d = 1'b0; bus_hwrite_d = 1'b0;
        @(negedge clk);
        bus_aph_req_d = 1'b0;
        #1;
        n_cmp++; if (bus_rdata_d !== (EXCL ? 32'h0A0A0A0A : 32'h0B0B0B0B) || bus_dph_exokay_d !== 1'b0) begin n_bad++; $display("FAIL excl_readback: got %h exokay=%b want %h 0", bus_rdata_d, bus_dph_exokay_d, EXCL ? 32'h0A0A0A0A : 32'h0B0B0B0B); end
    endtask

    task automatic test_reset_mid_write();
        logic we_seen;
        logic dph_seen;
        we_seen  = 1'b0;
        dph_seen = 1'b0;
        @(negedge clk);
        bus_aph_req_d = 1'b1; bus_haddr_d = 32'h8; bus_hsize_d = 3'd2; bus_hwrite_d = 1'b1;
        #1;
        n_cmp++; if (bus_aph_ready_d !== 1'b1) begin n_bad++; $display("FAIL rstmid_aph: got %b want 1", bus_aph_ready_d); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        bus_wdata_d = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            we_seen  = we_seen | mem_we;
            dph_seen = dph_seen | bus_dph_ready_i | bus_dph_ready_d | bus_dph_err_i | bus_dph_err_d | bus_dph_exokay_d;
            @(negedge clk);
            we_seen  = we_seen | mem_we;
            dph_seen = dph_seen | bus_dph_ready_i | bus_dph_ready_d | bus_dph_err_i | bus_dph_err_d | bus_dph_exokay_d;
            @(posedge clk);
        end
        n_cmp++; if (we_seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_we: got %b want 0", we_seen); end
        n_cmp++; if (dph_seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_dph: got %b want 0", dph_seen); end
        n_cmp++; if (ram[2] !== 32'h0BADF00D) begin n_bad++; $display("FAIL rstmid_ram: got %h want 0badf00d", ram[2]); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if ({bus_dph_ready_d, mem_we} !== 2'b00) begin n_bad++; $display("FAIL rstmid_after: got ready=%b we=%b want 0 0", bus_dph_ready_d, mem_we); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_arbitration();
        test_byte_store();
        test_half_store();
        test_error();
        test_exclusive();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
